// File: rtl/key_demux_pkg.sv
`default_nettype none
// ============================================================================
// key_demux_pkg : shared widths, defaults and destination type for key_demux_latch
// Rev 1.0 - initial release
// ============================================================================
package key_demux_pkg;

  localparam int DATA_W           = 7;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef enum logic {
    DEST_0 = 1'b0,
    DEST_1 = 1'b1
  } dest_e;

  // Counter must hold DEBOUNCE_CYCLES-1; at least one bit for the degenerate case.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : 2-flop synchronizer, stability counter and press detector
// Counter present only when KEY_DEBOUNCE_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
module key_debounce
  import key_demux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key_n,
  output logic press,
  output logic key_db
);

  logic sync_1;
  logic key_s;
  logic db_next;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      sync_1 <= key_n;
      key_s  <= sync_1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int              CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    db_next  = key_db;
    if (key_s != key_db) begin
      if (cnt == TERM) begin
        db_next = key_s;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = DEBOUNCE_CYCLES;
  assign db_next    = key_s;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_db <= 1'b1;
    end else begin
      key_db <= db_next;
    end
  end

  // Combinational so the load lands on the same edge key_db falls.
  assign press = key_db & ~db_next;

endmodule
`default_nettype wire

// File: rtl/key_demux_latch.sv
`default_nettype none
// ============================================================================
// key_demux_latch : debounced key loads a switch word into one of two registers
// Debounce counter enabled by defining KEY_DEBOUNCE_EN.
// Rev 1.0 - initial release
// ============================================================================
module key_demux_latch
  import key_demux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              key_n,
  input  logic              sel,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] hex0_n,
  output logic [DATA_W-1:0] hex1_n,
  output logic              load_pulse,
  output logic              last_dest
);

  logic  press;
  logic  key_db_unused;
  dest_e dest;
  dest_e dest_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .key_n    (key_n),
    .press    (press),
    .key_db   (key_db_unused)
  );

  assign dest = dest_e'(sel);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      out0       <= '0;
      out1       <= '0;
      dest_q     <= DEST_0;
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= press;
      if (press) begin
        dest_q <= dest;
        if (dest == DEST_0) begin
          out0 <= din;
        end else begin
          out1 <= din;
        end
      end
    end
  end

  assign last_dest = (dest_q == DEST_1);
  assign hex0_n    = ~out0;
  assign hex1_n    = ~out1;

endmodule
`default_nettype wire

// File: tb/tb_key_demux_latch.sv
`default_nettype none
// ============================================================================
// tb_key_demux_latch : directed self-checking bench for key_demux_latch
// Expectations adapt to whether KEY_DEBOUNCE_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
module tb_key_demux_latch;

  localparam int DEB = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int EFF          = DEB;
  localparam int BOUNCE_LOADS = 1;
  localparam int GLITCH_LOADS = 0;
`else
  localparam int EFF          = 1;
  localparam int BOUNCE_LOADS = 2;
  localparam int GLITCH_LOADS = 1;
`endif
  // Edges from first low sample to the load edge.
  localparam int LAT = EFF + 1;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       key_n   = 1'b1;
  logic       sel     = 1'b0;
  logic [6:0] din     = 7'h00;
  logic [6:0] out0, out1, hex0_n, hex1_n;
  logic       load_pulse, last_dest;

  int errors = 0;
  int checks = 0;
  int loads  = 0;
  int l0;

  key_demux_latch #(
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLOCK_50   (clk),
    .reset_n    (rst_n),
    .key_n      (key_n),
    .sel        (sel),
    .din        (din),
    .out0       (out0),
    .out1       (out1),
    .hex0_n     (hex0_n),
    .hex1_n     (hex1_n),
    .load_pulse (load_pulse),
    .last_dest  (last_dest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_pulse) loads++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    check_value("rst_out0", 32'(out0), 32'h00);
    check_value("rst_out1", 32'(out1), 32'h00);
    check_value("rst_hex0", 32'(hex0_n), 32'h7F);
    check_value("rst_hex1", 32'(hex1_n), 32'h7F);
    check_value("rst_load", 32'(load_pulse), 32'h0);
    check_value("rst_dest", 32'(last_dest), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Clean press into register 0
    din = 7'h5A; sel = 1'b0; key_n = 1'b0; l0 = loads;
    tick(LAT);
    check_value("clean_early_out0", 32'(out0), 32'h00);
    check_value("clean_early_load", 32'(load_pulse), 32'h0);
    tick(1);
    check_value("clean_out0", 32'(out0), 32'h5A);
    check_value("clean_load", 32'(load_pulse), 32'h1);
    check_value("clean_hex0", 32'(hex0_n), 32'h25);
    check_value("clean_out1", 32'(out1), 32'h00);
    check_value("clean_dest", 32'(last_dest), 32'h0);
    tick(1);
    check_value("clean_load_clr", 32'(load_pulse), 32'h0);
    check_value("clean_count", 32'(loads - l0), 32'd1);
    key_n = 1'b1;
    tick(LAT + 2);

    // Bouncy press into register 1
    din = 7'h33; sel = 1'b1; l0 = loads;
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(LAT + 8);
    check_value("bounce_count", 32'(loads - l0), 32'(BOUNCE_LOADS));
    check_value("bounce_out1", 32'(out1), 32'h33);
    check_value("bounce_dest", 32'(last_dest), 32'h1);
    check_value("bounce_out0", 32'(out0), 32'h5A);
    key_n = 1'b1;
    tick(LAT + 2);

    // Held key: one load in 100 cycles
    din = 7'h44; sel = 1'b1; l0 = loads;
    key_n = 1'b0; tick(100);
    check_value("held_count", 32'(loads - l0), 32'd1);
    check_value("held_out1", 32'(out1), 32'h44);
    key_n = 1'b1;
    tick(LAT + 2);

    // Re-press into register 0
    din = 7'h01; sel = 1'b0; l0 = loads;
    key_n = 1'b0; tick(LAT + 2);
    check_value("repress_out0", 32'(out0), 32'h01);
    check_value("repress_dest", 32'(last_dest), 32'h0);

    // Data/select change while still held
    din = 7'h7F; sel = 1'b1;
    tick(10);
    check_value("late_out0", 32'(out0), 32'h01);
    check_value("late_out1", 32'(out1), 32'h44);
    check_value("late_dest", 32'(last_dest), 32'h0);
    check_value("late_count", 32'(loads - l0), 32'd1);
    key_n = 1'b1;
    tick(LAT + 2);

    // Single-cycle glitch
    din = 7'h11; sel = 1'b1; l0 = loads;
    key_n = 1'b0; tick(1);
    key_n = 1'b1; tick(LAT + 6);
    check_value("glitch_count", 32'(loads - l0), 32'(GLITCH_LOADS));
    check_value("glitch_out1", 32'(out1), (GLITCH_LOADS != 0) ? 32'h11 : 32'h44);

    // Asynchronous reset in the middle of a debounce
    key_n = 1'b0; tick(2);
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_out0", 32'(out0), 32'h00);
    check_value("arst_out1", 32'(out1), 32'h00);
    check_value("arst_hex0", 32'(hex0_n), 32'h7F);
    check_value("arst_hex1", 32'(hex1_n), 32'h7F);
    check_value("arst_load", 32'(load_pulse), 32'h0);
    check_value("arst_dest", 32'(last_dest), 32'h0);
    tick(2);

    // Key held low across reset release: one load after full latency
    rst_n = 1'b1; l0 = loads;
    tick(LAT);
    check_value("hold_rst_early_out1", 32'(out1), 32'h00);
    check_value("hold_rst_early_load", 32'(load_pulse), 32'h0);
    tick(1);
    check_value("hold_rst_out1", 32'(out1), 32'h11);
    check_value("hold_rst_load", 32'(load_pulse), 32'h1);
    tick(20);
    check_value("hold_rst_count", 32'(loads - l0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
